// File: rtl/adder_arbiter_if.sv
// Client-side bus of adder_arbiter: two req/ack clients sharing one adder,
// plus the arbiter status outputs.
interface adder_arbiter_if;
  logic       req0, req1;
  logic [3:0] a0, b0, a1, b1;
  logic       ack0, ack1;
  logic [4:0] sum0, sum1;
  logic       busy;
  logic       gnt;

  modport master (output req0, a0, b0, req1, a1, b1,
                  input  ack0, sum0, ack1, sum1, busy, gnt);
  modport slave  (input  req0, a0, b0, req1, a1, b1,
                  output ack0, sum0, ack1, sum1, busy, gnt);
endinterface

// File: rtl/adder_arbiter.sv
// Two-client req/ack arbiter in front of one shared combinational adder.
// Operands are registered at grant so the adder only sees stable inputs.
module adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [4:0] c
);
  assign c = {1'b0, a} + {1'b0, b};
endmodule

module adder_arbiter #(
  parameter int RR_EN = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  adder_arbiter_if.slave  bus
);
  localparam int NUM_CLI = 2;

  typedef enum logic [1:0] {IDLE, ADD, HOLD} state_e;

  state_e                       state_q, state_d;
  logic [3:0]                   opa_q, opa_d, opb_q, opb_d;
  logic                         gnt_q, gnt_d, last_q, last_d;
  logic [NUM_CLI-1:0]           ack_q, ack_d;
  logic [NUM_CLI-1:0][4:0]      sum_q, sum_d;

  logic [NUM_CLI-1:0]           req;
  logic [NUM_CLI-1:0][3:0]      a, b;
  logic [4:0]                   c;
  logic                         win;

  assign req = {bus.req1, bus.req0};
  assign a   = {bus.a1, bus.a0};
  assign b   = {bus.b1, bus.b0};

  adder u_adder (.a(opa_q), .b(opb_q), .c(c));

  // Tie goes to the client not served last (RR) or to client 0 (fixed).
  always_comb begin
    win = req[1];
    if (req == 2'b11) win = (RR_EN != 0) ? ~last_q : 1'b0;
  end

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    ack_d   = ack_q;
    sum_d   = sum_q;
    case (state_q)
      IDLE: if (|req) begin
        state_d = ADD;
        opa_d   = a[win];
        opb_d   = b[win];
        gnt_d   = win;
      end
      ADD: begin
        sum_d[gnt_q] = c;
        ack_d[gnt_q] = 1'b1;
        state_d      = HOLD;
      end
      HOLD: if (!req[gnt_q]) begin
        ack_d[gnt_q] = 1'b0;
        last_d       = gnt_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      ack_q   <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      ack_q   <= ack_d;
      sum_q   <= sum_d;
    end
  end

  assign bus.ack0 = ack_q[0];
  assign bus.ack1 = ack_q[1];
  assign bus.sum0 = sum_q[0];
  assign bus.sum1 = sum_q[1];
  assign bus.busy = (state_q != IDLE);
  assign bus.gnt  = gnt_q;
endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter: one round-robin and one fixed-priority instance.
module tb_adder_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errs = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  adder_arbiter_if ifa ();
  adder_arbiter_if ifb ();

  adder_arbiter #(.RR_EN(1)) dut_rr  (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
  adder_arbiter #(.RR_EN(0)) dut_fix (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Bounded wait for ackN on the round-robin instance.
  task automatic wait_ack_a(input int cli, input string tag);
    int n;
    n = 0;
    while (((cli == 0) ? ifa.ack0 : ifa.ack1) !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_ack_timeout"}, 32'(n < 20), 32'd1);
  endtask

  task automatic txn_a1(input logic [3:0] av, input logic [3:0] bv, input logic [4:0] exp,
                        input string tag);
    ifa.a1 = av; ifa.b1 = bv; ifa.req1 = 1'b1;
    wait_ack_a(1, tag);
    chk({tag, "_sum1"}, 32'(ifa.sum1), 32'(exp));
    chk({tag, "_gnt"},  32'(ifa.gnt),  32'd1);
    ifa.req1 = 1'b0;
    tick();
    chk({tag, "_ack1_low"}, 32'(ifa.ack1), 32'd0);
  endtask

  initial begin
    ifa.req0 = 1'b0; ifa.req1 = 1'b0;
    ifa.a0 = '0; ifa.b0 = '0; ifa.a1 = '0; ifa.b1 = '0;
    ifb.req0 = 1'b0; ifb.req1 = 1'b0;
    ifb.a0 = '0; ifb.b0 = '0; ifb.a1 = '0; ifb.b1 = '0;

    // Reset with random activity on the inputs
    for (int i = 0; i < 4; i++) begin
      ifa.req0 = 1'($urandom); ifa.req1 = 1'($urandom);
      ifa.a0 = 4'($urandom); ifa.b0 = 4'($urandom);
      ifa.a1 = 4'($urandom); ifa.b1 = 4'($urandom);
      tick();
    end
    chk("rst_ack0", 32'(ifa.ack0), 32'd0);
    chk("rst_ack1", 32'(ifa.ack1), 32'd0);
    chk("rst_sum0", 32'(ifa.sum0), 32'd0);
    chk("rst_sum1", 32'(ifa.sum1), 32'd0);
    chk("rst_busy", 32'(ifa.busy), 32'd0);
    chk("rst_gnt",  32'(ifa.gnt),  32'd0);
    ifa.req0 = 1'b0; ifa.req1 = 1'b0;
    rst_n = 1'b1;
    tick(); tick();
    chk("idle_busy", 32'(ifa.busy), 32'd0);

    // Single client 0, exact latency
    ifa.a0 = 4'd9; ifa.b0 = 4'd7; ifa.req0 = 1'b1;
    tick();
    chk("s0_busy_e0", 32'(ifa.busy), 32'd1);
    chk("s0_ack_e0",  32'(ifa.ack0), 32'd0);
    tick();
    chk("s0_ack_e1",  32'(ifa.ack0), 32'd1);
    chk("s0_sum",     32'(ifa.sum0), 32'd16);
    chk("s0_gnt",     32'(ifa.gnt),  32'd0);
    tick();
    chk("s0_ack_hold", 32'(ifa.ack0), 32'd1);
    ifa.req0 = 1'b0;
    tick();
    chk("s0_ack_drop", 32'(ifa.ack0), 32'd0);
    chk("s0_busy_end", 32'(ifa.busy), 32'd0);
    chk("s0_sum_kept", 32'(ifa.sum0), 32'd16);

    // Extremes on client 1
    txn_a1(4'd15, 4'd15, 5'd30, "max");
    chk("max_sum0_kept", 32'(ifa.sum0), 32'd16);
    txn_a1(4'd0, 4'd0, 5'd0, "zero");
    chk("zero_sum0_kept", 32'(ifa.sum0), 32'd16);

    // Tie with last=1: client 0 first, then 1
    ifa.a0 = 4'd3; ifa.b0 = 4'd4; ifa.a1 = 4'd5; ifa.b1 = 4'd6;
    ifa.req0 = 1'b1; ifa.req1 = 1'b1;
    tick();
    chk("tie1_gnt0", 32'(ifa.gnt), 32'd0);
    tick();
    chk("tie1_ack0", 32'(ifa.ack0), 32'd1);
    chk("tie1_ack1", 32'(ifa.ack1), 32'd0);
    chk("tie1_sum0", 32'(ifa.sum0), 32'd7);
    ifa.req0 = 1'b0;
    tick();
    chk("tie1_ack0_low", 32'(ifa.ack0), 32'd0);
    tick();
    chk("tie1_gnt1", 32'(ifa.gnt), 32'd1);
    tick();
    chk("tie1_ack1_hi", 32'(ifa.ack1), 32'd1);
    chk("tie1_sum1",    32'(ifa.sum1), 32'd11);
    chk("tie1_sum0_kept", 32'(ifa.sum0), 32'd7);
    ifa.req1 = 1'b0;
    tick();

    // Serve 0 alone, then a tie must go to client 1
    ifa.a0 = 4'd1; ifa.b0 = 4'd1; ifa.req0 = 1'b1;
    wait_ack_a(0, "solo0");
    chk("solo0_sum0", 32'(ifa.sum0), 32'd2);
    ifa.req0 = 1'b0;
    tick();
    ifa.a0 = 4'd8; ifa.b0 = 4'd8; ifa.a1 = 4'd2; ifa.b1 = 4'd12;
    ifa.req0 = 1'b1; ifa.req1 = 1'b1;
    tick();
    chk("tie2_gnt1", 32'(ifa.gnt), 32'd1);
    tick();
    chk("tie2_ack1", 32'(ifa.ack1), 32'd1);
    chk("tie2_sum1", 32'(ifa.sum1), 32'd14);
    chk("tie2_ack0", 32'(ifa.ack0), 32'd0);
    ifa.req1 = 1'b0;
    tick();
    wait_ack_a(0, "tie2_second");
    chk("tie2_sum0", 32'(ifa.sum0), 32'd16);
    chk("tie2_sum1_kept", 32'(ifa.sum1), 32'd14);
    ifa.req0 = 1'b0;
    tick();

    // Fixed priority: client 1 starves while req0 keeps coming back
    ifb.a0 = 4'd1; ifb.b0 = 4'd2; ifb.a1 = 4'd7; ifb.b1 = 4'd8;
    ifb.req0 = 1'b1; ifb.req1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("fix%0d_gnt", i), 32'(ifb.gnt), 32'd0);
      tick();
      chk($sformatf("fix%0d_ack0", i), 32'(ifb.ack0), 32'd1);
      chk($sformatf("fix%0d_ack1", i), 32'(ifb.ack1), 32'd0);
      ifb.req0 = 1'b0;
      tick();
      if (i < 3) ifb.req0 = 1'b1;
    end
    chk("fix_sum0", 32'(ifb.sum0), 32'd3);
    chk("fix_sum1_starved", 32'(ifb.sum1), 32'd0);
    tick();
    chk("fix_gnt1", 32'(ifb.gnt), 32'd1);
    tick();
    chk("fix_ack1", 32'(ifb.ack1), 32'd1);
    chk("fix_sum1", 32'(ifb.sum1), 32'd15);
    ifb.req1 = 1'b0;
    tick();
    chk("fix_busy_end", 32'(ifb.busy), 32'd0);

    // Reset while in HOLD, then re-sample the still-high request
    ifa.a0 = 4'd10; ifa.b0 = 4'd5; ifa.req0 = 1'b1;
    tick(); tick();
    chk("rh_ack0", 32'(ifa.ack0), 32'd1);
    chk("rh_sum0", 32'(ifa.sum0), 32'd15);
    #2 rst_n = 1'b0;
    #1;
    chk("rh_ack0_async", 32'(ifa.ack0), 32'd0);
    chk("rh_sum0_async", 32'(ifa.sum0), 32'd0);
    ifa.a0 = 4'd2; ifa.b0 = 4'd2;
    tick();
    rst_n = 1'b1;
    tick();
    chk("rh_busy_e0", 32'(ifa.busy), 32'd1);
    tick();
    chk("rh_ack0_new", 32'(ifa.ack0), 32'd1);
    chk("rh_sum0_new", 32'(ifa.sum0), 32'd4);
    ifa.req0 = 1'b0;
    tick();
    chk("rh_ack0_low", 32'(ifa.ack0), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
